// File: rtl/mprj_wb_arbiter.sv
// Two-master / one-slave Wishbone arbiter for the user-project port.
// Round-robin ties, cyc-held grants, and a per-transfer ack watchdog that aborts hung slaves.
module mprj_wb_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        mprj_cyc_o,
  output logic        mprj_stb_o,
  output logic        mprj_we_o,
  output logic [3:0]  mprj_sel_o,
  output logic [31:0] mprj_adr_o,
  output logic [31:0] mprj_dat_o,
  input  logic        mprj_ack_i,
  input  logic [31:0] mprj_dat_i,
  output logic        mprj_wb_iena,
  input  logic        to_clr,
  output logic        timeout_flag,
  output logic        grant,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a master requests with cyc&stb; a transfer completes on the cycle the
  // routed ack is high; the owner keeps the bus until it drops cyc.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUS0  = 2'd1,
    S_BUS1  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] LIMIT = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  state_t          r_state;
  state_t          w_next;
  logic            r_last_grant;
  logic            r_owner;
  logic            r_timeout_flag;
  logic            r_err0;
  logic            r_err1;
  logic [TO_W-1:0] r_cnt;

  logic w_req0;
  logic w_req1;
  logic w_in_bus;
  logic w_expire;
  logic w_grant;

  assign w_req0   = m0_cyc_i & m0_stb_i;
  assign w_req1   = m1_cyc_i & m1_stb_i;
  assign w_in_bus = (r_state == S_BUS0) || (r_state == S_BUS1);
  assign w_expire = (TIMEOUT != 0) && w_in_bus && mprj_stb_o && !mprj_ack_i && (r_cnt == LIMIT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req0 && w_req1) w_next = r_last_grant ? S_BUS0 : S_BUS1;
        else if (w_req0)      w_next = S_BUS0;
        else if (w_req1)      w_next = S_BUS1;
      end
      S_BUS0: begin
        if (!m0_cyc_i)     w_next = S_IDLE;
        else if (w_expire) w_next = S_ABORT;
      end
      S_BUS1: begin
        if (!m1_cyc_i)     w_next = S_IDLE;
        else if (w_expire) w_next = S_ABORT;
      end
      default: begin
        if (!(r_owner ? m1_cyc_i : m0_cyc_i)) w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_grant      = r_last_grant;
    mprj_cyc_o   = 1'b0;
    mprj_stb_o   = 1'b0;
    mprj_we_o    = 1'b0;
    mprj_sel_o   = 4'h0;
    mprj_adr_o   = 32'h0;
    mprj_dat_o   = 32'h0;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;
    mprj_wb_iena = w_in_bus;
    case (r_state)
      S_BUS0: begin
        w_grant    = 1'b0;
        mprj_cyc_o = m0_cyc_i;
        mprj_stb_o = m0_stb_i;
        mprj_we_o  = m0_we_i;
        mprj_sel_o = m0_sel_i;
        mprj_adr_o = m0_adr_i;
        mprj_dat_o = m0_dat_i;
        m0_ack_o   = mprj_ack_i;
      end
      S_BUS1: begin
        w_grant    = 1'b1;
        mprj_cyc_o = m1_cyc_i;
        mprj_stb_o = m1_stb_i;
        mprj_we_o  = m1_we_i;
        mprj_sel_o = m1_sel_i;
        mprj_adr_o = m1_adr_i;
        mprj_dat_o = m1_dat_i;
        m1_ack_o   = mprj_ack_i;
      end
      S_ABORT: w_grant = r_owner;
      default: w_grant = r_last_grant;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      r_state        <= S_IDLE;
      r_last_grant   <= 1'b1;
      r_owner        <= 1'b0;
      r_timeout_flag <= 1'b0;
      r_err0         <= 1'b0;
      r_err1         <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_state <= w_next;
      if (w_in_bus) r_owner <= (r_state == S_BUS1);
      if ((r_state != S_IDLE) && (w_next == S_IDLE)) r_last_grant <= w_grant;
      r_err0 <= w_expire && (r_state == S_BUS0);
      r_err1 <= w_expire && (r_state == S_BUS1);
      // Setting wins over a simultaneous clear so an abort is never lost.
      if (w_expire)    r_timeout_flag <= 1'b1;
      else if (to_clr) r_timeout_flag <= 1'b0;
      if ((w_next != r_state) || !w_in_bus || !mprj_stb_o || mprj_ack_i) r_cnt <= '0;
      else                                                               r_cnt <= r_cnt + 1'b1;
    end
  end

  assign m0_err_o     = r_err0;
  assign m1_err_o     = r_err1;
  assign m0_dat_o     = mprj_dat_i;
  assign m1_dat_o     = mprj_dat_i;
  assign timeout_flag = r_timeout_flag;
  assign grant        = w_grant;
  assign o_dbg_state  = r_state;

endmodule
